// File: rtl/gate_stim_checker.sv
// gate_stim_checker: clocked stimulus sequencer and checker for a small combinational gate.
// It sweeps every input combination of the gate in ascending order and holds each one for
// HOLD_CYCLES cycles. On the last cycle of each hold it samples the gate output and compares
// it with the selected logic function. It reports the error count, the first failing vector
// and an overall pass flag.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   single-cycle sweep request, honoured in IDLE or DONE only
//   op_sel     in   expected function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6-7 illegal
//   dut_y      in   output of the gate under test
//   stim       out  gate inputs (bit 0 = a, bit 1 = b, ...)
//   busy       out  sweep in progress
//   done       out  sweep finished; results valid until the next accepted start or reset
//   pass       out  no mismatches and legal op_sel (valid with done)
//   err_count  out  saturating count of mismatching vectors
//   first_fail out  first mismatching vector, 0 if none
//   cfg_err    out  latched op_sel was illegal (raised with done)
module gate_stim_checker #(
    parameter int unsigned N_IN        = 2,
    parameter int unsigned HOLD_CYCLES = 5,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op_sel,
    input  logic             dut_y,
    output logic [N_IN-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [N_IN-1:0]  first_fail,
    output logic             cfg_err
);

    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned VW = N_IN + 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [VW-1:0]    VEC_LAST  = VW'((1 << N_IN) - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [VW-1:0]     vec_q, vec_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [2:0]        op_q, op_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [N_IN-1:0]   ff_q, ff_d;
    logic              cfg_q, cfg_d;
    // Tracks whether a mismatch has been recorded; first_fail==0 is itself a valid vector.
    logic              seen_q, seen_d;

    logic              op_legal_q;
    logic              exp_y;
    logic              mismatch;

    assign op_legal_q = (op_q < 3'd6);

    always_comb begin
        exp_y = 1'b0;
        case (op_q)
            3'd0:    exp_y = &vec_q[N_IN-1:0];
            3'd1:    exp_y = |vec_q[N_IN-1:0];
            3'd2:    exp_y = ^vec_q[N_IN-1:0];
            3'd3:    exp_y = ~&vec_q[N_IN-1:0];
            3'd4:    exp_y = ~|vec_q[N_IN-1:0];
            3'd5:    exp_y = ~^vec_q[N_IN-1:0];
            default: exp_y = 1'b0;
        endcase
    end

    assign mismatch = (dut_y != exp_y);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        op_d    = op_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ff_d    = ff_q;
        cfg_d   = cfg_q;
        seen_d  = seen_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    op_d    = op_sel;
                    err_d   = '0;
                    ff_d    = '0;
                    pass_d  = 1'b0;
                    done_d  = 1'b0;
                    cfg_d   = 1'b0;
                    seen_d  = 1'b0;
                    vec_d   = '0;
                    hold_d  = '0;
                    state_d = StRun;
                    // An illegal op only passes through RUN for one cycle; busy stays low.
                    busy_d  = (op_sel < 3'd6);
                end
            end
            StRun: begin
                if (!op_legal_q) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    cfg_d   = 1'b1;
                    pass_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (hold_q == HOLD_LAST) begin
                    if (mismatch) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + ERR_W'(1);
                        end
                        if (!seen_q) begin
                            ff_d   = vec_q[N_IN-1:0];
                            seen_d = 1'b1;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_q == '0) && !mismatch;
                    end else begin
                        vec_d  = vec_q + VW'(1);
                        hold_d = '0;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vec_q   <= '0;
            hold_q  <= '0;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
            cfg_q   <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            cfg_q   <= cfg_d;
            seen_q  <= seen_d;
        end
    end

    assign stim       = vec_q[N_IN-1:0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;
    assign cfg_err    = cfg_q;

endmodule
